// File: rtl/audio_record_writer_pkg.sv
// Shared types and constants for the audio record writer.
//   record_state_t   : take FSM states
//   SAMPLES_PER_WORD : 16-bit samples packed per DRAM word
//   WORD_WIDTH       : DRAM word width in bits
package audio_record_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    FLUSH   = 2'd2,
    DONE    = 2'd3
  } record_state_t;

  localparam int SAMPLES_PER_WORD = 8;
  localparam int SAMPLE_WIDTH     = 16;
  localparam int WORD_WIDTH       = SAMPLES_PER_WORD * SAMPLE_WIDTH;

endpackage

// File: rtl/audio_record_writer_if.sv
// DRAM write-client port of the record writer.
//   wr_addr  : word address
//   wr_data  : packed word, sample 0 (oldest) in bits [15:0]
//   wr_valid : request pending
//   wr_ready : DRAM accepts when wr_valid && wr_ready
// master = record writer, slave = DRAM arbiter.
interface audio_record_writer_if #(
  parameter int ADDR_WIDTH = 24
);
  import audio_record_pkg::*;

  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [WORD_WIDTH-1:0] wr_data;
  logic                  wr_valid;
  logic                  wr_ready;

  modport master (output wr_addr, output wr_data, output wr_valid, input  wr_ready);
  modport slave  (input  wr_addr, input  wr_data, input  wr_valid, output wr_ready);

endinterface

// File: rtl/audio_record_writer_fifo.sv
// record_word_fifo: synchronous word FIFO between the packer and the DRAM
// write register.
//   push/push_data : write a word (ignored when full)
//   pop            : drop the head (ignored when empty)
//   head           : oldest entry
//   next           : entry behind the head, valid when multi=1
//   full/empty     : occupancy flags
//   multi          : at least two entries held
// Pointers wrap modulo FIFO_DEPTH; a separate full flag disambiguates
// equal pointers.
module record_word_fifo
  import audio_record_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WORD_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [WORD_WIDTH-1:0] head,
  output logic [WORD_WIDTH-1:0] next,
  output logic                  full,
  output logic                  empty,
  output logic                  multi
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [WORD_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr, fill;
  logic                  full_q;
  logic                  do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr) && !full_q;
  assign full    = full_q;
  assign fill    = wr_ptr - rd_ptr;
  assign multi   = full_q || (fill > PTR_W'(1));
  assign do_push = push && !full_q;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];
  assign next    = mem[rd_ptr + PTR_W'(1)];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop && (wr_ptr + PTR_W'(1) == rd_ptr)) full_q <= 1'b1;
      else if (do_pop && !do_push)                               full_q <= 1'b0;
    end
  end

endmodule

// File: rtl/audio_record_writer.sv
// audio_record_writer: records a valid-strobed 16-bit sample stream into
// DRAM as packed 128-bit words at consecutive word addresses.
//   clk, rst               : clock, async active-low reset
//   record_start/stop      : single-cycle take control pulses
//   base_addr, max_words   : take parameters, latched on accepted start
//                            (max_words 0 = unlimited)
//   sample_in(_valid)      : sample stream, one strobe per sample
//   wr                     : DRAM write port (valid/ready)
//   busy, done             : FSM not idle / one-cycle end-of-take pulse
//   recorded_words         : words accepted by DRAM this/last take (saturating)
//   overflow               : sticky, a packed word was dropped on a full FIFO
module audio_record_writer
  import audio_record_pkg::*;
#(
  parameter int ADDR_WIDTH = 24,
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_WIDTH  = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   record_start,
  input  logic                   record_stop,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [LEN_WIDTH-1:0]   max_words,
  input  logic [15:0]            sample_in,
  input  logic                   sample_in_valid,
  audio_record_writer_if.master  wr,
  output logic                   busy,
  output logic                   done,
  output logic [LEN_WIDTH-1:0]   recorded_words,
  output logic                   overflow
);

  localparam int CNT_W = $clog2(SAMPLES_PER_WORD);

  record_state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] base_q, offset_q, wr_addr_q;
  logic [LEN_WIDTH-1:0]  max_q, words_packed_q, recorded_q;
  logic [WORD_WIDTH-1:0] wr_data_q;
  logic                  wr_valid_q, overflow_q;

  logic [SAMPLES_PER_WORD-1:0][SAMPLE_WIDTH-1:0] lanes_q, word_d;
  logic [CNT_W-1:0]      count_q;

  logic                  in_capture, start_acc, limit_hit, take_sample;
  logic                  full_word, pad_push, push_req, handshake;
  logic [WORD_WIDTH-1:0] fifo_head, fifo_next;
  logic                  fifo_full, fifo_empty, fifo_multi;

  // ---------------- FSM ----------------
  assign in_capture = (state_q == CAPTURE);
  assign start_acc  = (state_q == IDLE) && record_start;
  assign limit_hit  = (max_q != '0) && (words_packed_q == max_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (record_start)              state_d = CAPTURE;
      CAPTURE: if (record_stop || limit_hit)  state_d = FLUSH;
      FLUSH:   if (fifo_empty && !wr_valid_q) state_d = DONE;
      DONE:                                   state_d = IDLE;
      default:                                state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  // ---------------- Packer ----------------
  // Once the word limit is reached, further samples are ignored even in the
  // one cycle before the FSM reaches FLUSH.
  always_comb begin
    take_sample = in_capture && sample_in_valid && !limit_hit;
    word_d      = lanes_q;
    if (take_sample) word_d[count_q] = sample_in;
    full_word   = take_sample && (count_q == CNT_W'(SAMPLES_PER_WORD - 1));
    // Lanes are cleared after every push, so a partial word is already
    // zero-padded above the last written lane.
    pad_push    = in_capture && record_stop && !limit_hit && !full_word &&
                  (take_sample || (count_q != '0));
    push_req    = full_word || pad_push;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lanes_q        <= '0;
      count_q        <= '0;
      words_packed_q <= '0;
      overflow_q     <= 1'b0;
      base_q         <= '0;
      max_q          <= '0;
    end else if (start_acc) begin
      lanes_q        <= '0;
      count_q        <= '0;
      words_packed_q <= '0;
      overflow_q     <= 1'b0;
      base_q         <= base_addr;
      max_q          <= max_words;
    end else if (push_req) begin
      lanes_q        <= '0;
      count_q        <= '0;
      // Dropped words still count so the limit tracks captured time.
      words_packed_q <= words_packed_q + 1'b1;
      if (fifo_full) overflow_q <= 1'b1;
    end else if (take_sample) begin
      lanes_q <= word_d;
      count_q <= count_q + 1'b1;
    end
  end

  record_word_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_req),
    .push_data (word_d),
    .pop       (handshake),
    .head      (fifo_head),
    .next      (fifo_next),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .multi     (fifo_multi)
  );

  // ---------------- Write port ----------------
  // The presented word stays in the FIFO until DRAM accepts it, so the FIFO
  // alone bounds how many words can be outstanding.
  assign handshake = wr_valid_q && wr.wr_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      offset_q   <= '0;
      recorded_q <= '0;
    end else if (start_acc) begin
      offset_q   <= '0;
      recorded_q <= '0;
    end else if (handshake) begin
      offset_q <= offset_q + 1'b1;
      if (recorded_q != '1) recorded_q <= recorded_q + 1'b1;
      if (fifo_multi) begin
        wr_data_q <= fifo_next;
        wr_addr_q <= base_q + offset_q + 1'b1;
      end else begin
        wr_valid_q <= 1'b0;
      end
    end else if (!wr_valid_q && !fifo_empty) begin
      wr_data_q  <= fifo_head;
      wr_addr_q  <= base_q + offset_q;
      wr_valid_q <= 1'b1;
    end
  end

  assign wr.wr_addr     = wr_addr_q;
  assign wr.wr_data     = wr_data_q;
  assign wr.wr_valid    = wr_valid_q;
  assign recorded_words = recorded_q;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_audio_record_writer.sv
// Testbench for audio_record_writer: table of takes plus hand-written
// sequences (overflow with stalled DRAM, reset during a stalled write).
module tb_audio_record_writer;
  import audio_record_pkg::*;

  localparam int AW = 24;
  localparam int LW = 20;
  localparam int FD = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          record_start = 1'b0, record_stop = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [LW-1:0] max_words = '0;
  logic [15:0]   sample_in = '0;
  logic          sample_in_valid = 1'b0;
  logic          busy, done, overflow;
  logic [LW-1:0] recorded_words;

  bit ready_rand = 1'b0;
  bit ready_lvl  = 1'b1;

  always #5 clk = ~clk;

  audio_record_writer_if #(.ADDR_WIDTH(AW)) wr_if ();

  audio_record_writer #(.ADDR_WIDTH(AW), .FIFO_DEPTH(FD), .LEN_WIDTH(LW)) dut (
    .clk             (clk),
    .rst             (rst),
    .record_start    (record_start),
    .record_stop     (record_stop),
    .base_addr       (base_addr),
    .max_words       (max_words),
    .sample_in       (sample_in),
    .sample_in_valid (sample_in_valid),
    .wr              (wr_if),
    .busy            (busy),
    .done            (done),
    .recorded_words  (recorded_words),
    .overflow        (overflow)
  );

  always @(posedge clk) begin
    #1;
    wr_if.wr_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_lvl;
  end

  // ---------------- monitor ----------------
  logic [AW-1:0]  obs_addr [512];
  logic [127:0]   obs_data [512];
  int             obs_n = 0, done_cnt = 0, stall_chk = 0, stall_bad = 0, busy_bad = 0;
  logic           prev_stall = 1'b0, prev_done = 1'b0;
  logic [AW-1:0]  prev_addr;
  logic [127:0]   prev_data;

  always @(negedge clk) begin
    if (wr_if.wr_valid && wr_if.wr_ready) begin
      if (obs_n < 512) begin
        obs_addr[obs_n] = wr_if.wr_addr;
        obs_data[obs_n] = wr_if.wr_data;
      end
      obs_n++;
    end
    if (prev_stall && wr_if.wr_valid) begin
      stall_chk++;
      if (wr_if.wr_addr !== prev_addr || wr_if.wr_data !== prev_data) stall_bad++;
    end
    prev_stall = wr_if.wr_valid && !wr_if.wr_ready;
    prev_addr  = wr_if.wr_addr;
    prev_data  = wr_if.wr_data;
    if (prev_done && busy) busy_bad++;
    prev_done = done;
    if (done) done_cnt++;
  end

  // ---------------- checking helpers ----------------
  int n_checks = 0, n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [15:0]   smp [$];
  logic [AW-1:0] exp_a [$];
  logic [127:0]  exp_d [$];

  // Reference packing: 8 samples per word, oldest in the low lane, limit
  // stops the take, a trailing partial word is zero-padded. Only the first
  // 'cap' words are expected to reach DRAM.
  task automatic model(input logic [AW-1:0] base, input int maxw, input int cap);
    logic [127:0] w;
    int lane, words;
    bit lim;
    w = '0; lane = 0; words = 0; lim = 1'b0;
    foreach (smp[i]) if (!lim) begin
      w[lane*16 +: 16] = smp[i];
      lane++;
      if (lane == 8) begin
        if (words < cap) begin
          exp_a.push_back(base + AW'(words));
          exp_d.push_back(w);
        end
        words++; w = '0; lane = 0;
        if (maxw != 0 && words == maxw) lim = 1'b1;
      end
    end
    if (!lim && lane != 0 && words < cap) begin
      exp_a.push_back(base + AW'(words));
      exp_d.push_back(w);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [AW-1:0] b, input int m, input bit with_stop);
    base_addr    = b;
    max_words    = LW'(m);
    record_start = 1'b1;
    record_stop  = with_stop;
    tick();
    record_start = 1'b0;
    record_stop  = 1'b0;
  endtask

  task automatic feed(input int gap, input bit stop_last);
    foreach (smp[i]) begin
      sample_in       = smp[i];
      sample_in_valid = 1'b1;
      record_stop     = stop_last && (i == smp.size() - 1);
      tick();
      sample_in_valid = 1'b0;
      record_stop     = 1'b0;
      repeat (gap) tick();
    end
    if (!stop_last) begin
      record_stop = 1'b1;
      tick();
      record_stop = 1'b0;
    end
  endtask

  task automatic wait_done(input string name, input int d0);
    int k;
    k = 0;
    while (done_cnt == d0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (done_cnt == d0) begin
      n_fail++;
      $display("FAIL %s done: no pulse within 3000 cycles", name);
    end
    @(negedge clk);
    chk({name, " busy after done"}, 128'(busy), 128'(0));
  endtask

  task automatic compare_writes(input string name, input int first);
    int i;
    logic [AW-1:0] ea;
    logic [127:0]  ed;
    chk({name, " write count"}, 128'(obs_n - first), 128'(exp_a.size()));
    i = 0;
    while (exp_a.size() > 0) begin
      ea = exp_a.pop_front();
      ed = exp_d.pop_front();
      if (first + i < obs_n && first + i < 512) begin
        chk($sformatf("%s addr[%0d]", name, i), 128'(obs_addr[first+i]), 128'(ea));
        chk($sformatf("%s data[%0d]", name, i), obs_data[first+i], ed);
      end
      i++;
    end
  endtask

  // ---------------- take table ----------------
  typedef struct {
    logic [AW-1:0] base;
    int            maxw;
    int            nsamp;
    logic [15:0]   first;
    logic [15:0]   step;
    bit            rnd;
    int            gap;
    bit            stop_last;
    bit            start_stop;
    bit            rrand;
    int            exp_rec;
  } take_t;

  take_t tbl [6];

  initial begin
    int first, d0, s0, sb0, k;
    string nm;

    tbl[0] = '{24'h000100, 0, 16, 16'h0001, 16'h0001, 1'b0, 0, 1'b0, 1'b0, 1'b0, 2};
    tbl[1] = '{24'h000200, 0,  3, 16'hAAAA, 16'h0000, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1};
    tbl[2] = '{24'h000300, 2, 24, 16'h0100, 16'h0001, 1'b0, 0, 1'b0, 1'b0, 1'b0, 2};
    tbl[3] = '{24'hFFFFFF, 0, 16, 16'h5000, 16'h0003, 1'b0, 0, 1'b0, 1'b0, 1'b0, 2};
    tbl[4] = '{24'h001000, 0, 20, 16'h0000, 16'h0000, 1'b1, 2, 1'b1, 1'b0, 1'b1, 3};
    tbl[5] = '{24'h002000, 0,  8, 16'h7000, 16'h0001, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1};

    // Reset state, checked before the first clock edge.
    #3;
    chk("reset wr_valid", 128'(wr_if.wr_valid), 128'(0));
    chk("reset wr_addr",  128'(wr_if.wr_addr),  128'(0));
    chk("reset wr_data",  wr_if.wr_data,        128'(0));
    chk("reset busy",     128'(busy),           128'(0));
    chk("reset done",     128'(done),           128'(0));
    chk("reset recorded", 128'(recorded_words), 128'(0));
    chk("reset overflow", 128'(overflow),       128'(0));
    tick(); tick();
    rst = 1'b1;
    tick();

    for (int t = 0; t < 6; t++) begin
      nm = $sformatf("take%0d", t);
      smp.delete();
      for (int i = 0; i < tbl[t].nsamp; i++)
        smp.push_back(tbl[t].rnd ? 16'($urandom) : 16'(tbl[t].first + tbl[t].step * i));
      model(tbl[t].base, tbl[t].maxw, 1000);
      ready_rand = tbl[t].rrand;
      ready_lvl  = 1'b1;
      first = obs_n;
      d0    = done_cnt;
      do_start(tbl[t].base, tbl[t].maxw, tbl[t].start_stop);
      @(negedge clk);
      chk({nm, " busy after start"}, 128'(busy), 128'(1));
      feed(tbl[t].gap, tbl[t].stop_last);
      wait_done(nm, d0);
      compare_writes(nm, first);
      chk({nm, " recorded_words"}, 128'(recorded_words), 128'(tbl[t].exp_rec));
      chk({nm, " overflow"},       128'(overflow),       128'(0));
      if (t == 0)
        chk("take0 word0 literal", obs_data[first], 128'h0008_0007_0006_0005_0004_0003_0002_0001);
      if (t == 3)
        chk("take3 wrapped addr", 128'(obs_addr[first+1]), 128'(0));
      ready_rand = 1'b0;
      tick();
    end

    // Overflow: DRAM stalled while FD+2 words are captured.
    nm = "ovf";
    ready_lvl = 1'b0;
    tick();
    smp.delete();
    for (int i = 0; i < 8 * (FD + 2); i++) smp.push_back(16'(i * 3 + 5));
    model(24'h004000, 0, FD);
    first = obs_n; d0 = done_cnt; s0 = stall_chk; sb0 = stall_bad;
    do_start(24'h004000, 0, 1'b0);
    feed(0, 1'b0);
    repeat (4) tick();
    @(negedge clk);
    chk("ovf overflow while stalled", 128'(overflow), 128'(1));
    chk("ovf wr_valid while stalled", 128'(wr_if.wr_valid), 128'(1));
    ready_lvl = 1'b1;
    wait_done(nm, d0);
    compare_writes(nm, first);
    chk("ovf recorded_words", 128'(recorded_words), 128'(FD));
    chk("ovf overflow sticky", 128'(overflow), 128'(1));
    chk("ovf stall cycles observed", 128'(stall_chk > s0 + 100), 128'(1));
    chk("ovf stall stability", 128'(stall_bad - sb0), 128'(0));

    // Reset while a word is presented and stalled.
    ready_lvl = 1'b0;
    tick();
    smp.delete();
    for (int i = 0; i < 8; i++) smp.push_back(16'(16'h0B00 + i));
    first = obs_n; d0 = done_cnt;
    do_start(24'h000500, 0, 1'b0);
    feed(0, 1'b0);
    k = 0;
    while (!wr_if.wr_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("rst stalled word presented", 128'(wr_if.wr_valid), 128'(1));
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("rst async wr_valid", 128'(wr_if.wr_valid), 128'(0));
    chk("rst async wr_addr",  128'(wr_if.wr_addr),  128'(0));
    chk("rst async wr_data",  wr_if.wr_data,        128'(0));
    chk("rst async busy",     128'(busy),           128'(0));
    chk("rst async recorded", 128'(recorded_words), 128'(0));
    chk("rst async overflow", 128'(overflow),       128'(0));
    repeat (3) @(negedge clk);
    chk("rst no done pulse", 128'(done_cnt - d0), 128'(0));
    chk("rst no write",      128'(obs_n - first), 128'(0));
    tick();
    rst = 1'b1;
    ready_lvl = 1'b1;
    tick();

    nm = "post_rst";
    smp.delete();
    for (int i = 0; i < 8; i++) smp.push_back(16'(16'h0C00 + i));
    model(24'h000600, 0, 1000);
    first = obs_n; d0 = done_cnt;
    do_start(24'h000600, 0, 1'b0);
    feed(0, 1'b0);
    wait_done(nm, d0);
    compare_writes(nm, first);
    chk("post_rst recorded_words", 128'(recorded_words), 128'(1));

    chk("busy low right after every done", 128'(busy_bad), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_record_writer.md
Name: audio_record_writer

Overview:
- Write-side counterpart of the DRAM sample playback path. It captures a 48 kHz-domain 16-bit sample stream (valid-strobed, the same format the effect chain produces) and packs samples into 128-bit words.
- Words are buffered and issued to the DRAM write port over a valid/ready handshake at consecutive word addresses.
- Sits between the audio_multi_mux output tap and the DRAM arbiter's write client, so a recorded take can later be replayed through the normal playback path.

Parameters:
- ADDR_WIDTH, 24, DRAM word-address width.
- FIFO_DEPTH, 16, word FIFO depth in 128-bit words; power of two, at least 2.
- LEN_WIDTH, 20, width of the max_words and recorded_words counters.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- record_start  in  1  single-cycle start pulse
- record_stop  in  1  single-cycle stop pulse
- base_addr  in  ADDR_WIDTH  first word address; sampled on accepted start
- max_words  in  LEN_WIDTH  word limit; sampled on accepted start; 0 means unlimited
- sample_in  in  16  signed sample
- sample_in_valid  in  1  one-cycle strobe per sample
- wr_addr  out  ADDR_WIDTH  DRAM word address
- wr_data  out  128  packed samples; sample k occupies bits [16k+15:16k]; sample 0 is the oldest
- wr_valid  out  1  write request
- wr_ready  in  1  DRAM accepts the request when wr_valid && wr_ready
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at the end of a take
- recorded_words  out  LEN_WIDTH  words accepted by DRAM in the current or last take
- overflow  out  1  sticky; set when a packed word is dropped; cleared on accepted start

Behaviour:
- Reset (rst low, asynchronous): state IDLE; all outputs 0; FIFO empty; packer count 0.
- States and transitions:
  - IDLE: start goes to CAPTURE; stop is ignored. Start and stop in the same cycle: start wins and stop is dropped.
  - CAPTURE: start is ignored. Leaves to FLUSH on stop, or when words_packed == max_words with max_words != 0.
  - FLUSH: drains the FIFO; goes to DONE when the FIFO is empty and no handshake is pending.
  - DONE: one cycle with done=1, then IDLE.
- Accepted start: latches base_addr and max_words; clears recorded_words, overflow, packer count and the address offset.
- Packer (CAPTURE only): each sample_in_valid writes sample_in into lane `count` and increments count.
  - At count 7 the completed word is pushed to the FIFO the same cycle and count wraps to 0.
  - If the FIFO is full at push time, the word is dropped, overflow is set, and words_packed still increments (timing is preserved).
  - Samples arriving outside CAPTURE are ignored.
- Stop with 0 < count < 8: the partial word is zero-padded in the upper lanes and pushed on the cycle the FSM enters FLUSH. The overflow rule applies if the FIFO is full. With count 0, nothing is pushed.
- A sample_in_valid in the same cycle as stop is packed before the padding.
- Write port:
  - When the FIFO is non-empty and wr_valid=0, the head is registered onto wr_data/wr_addr and wr_valid is asserted on the next cycle.
  - wr_data and wr_addr hold stable while wr_valid && !wr_ready.
  - On handshake: pop the FIFO, increment the address offset and recorded_words.
  - Back-to-back handshakes are allowed: wr_valid stays high if another word is queued.
- wr_addr = base_addr + offset, modulo 2^ADDR_WIDTH; it wraps silently.
- recorded_words saturates at all-ones. FIFO pointers wrap modulo FIFO_DEPTH with a separate full/empty flag.
- Latency: a full word appears on wr_valid 2 cycles after its 8th sample strobe when the FIFO was empty.
- Reset mid-take: the take is aborted immediately with no done pulse; no partial word is written.

Decomposition:
- Package audio_record_pkg holds:
  - typedef enum record_state_t {IDLE, CAPTURE, FLUSH, DONE};
  - localparam SAMPLES_PER_WORD = 8;
  - localparam WORD_WIDTH = 128.
- One sub-module, record_word_fifo: synchronous FIFO, WORD_WIDTH wide, FIFO_DEPTH deep, with push/pop/full/empty. It uses the same clock and asynchronous active-low reset.
- Packer, FSM and write-port register stay in the top module.

Test Plan:
- Start with base_addr=0x000100, max_words=0, then 16 samples 0x0001..0x0010 with wr_ready=1, then stop.
  - Expect two writes: addr 0x000100 with data 0x0008_0007_..._0001, and addr 0x000101 with 0x0010_..._0009.
  - Expect done 1 cycle after the FIFO drains, recorded_words=2, overflow=0.
- Send 3 samples 0xAAAA then stop.
  - Expect one write with lanes 0-2 = 0xAAAA and lanes 3-7 = 0, then done; busy falls on the cycle after done.
- Start with max_words=2 and feed 24 samples.
  - Expect exactly 2 writes; samples 17-24 are ignored; FSM goes to FLUSH automatically.
- Hold wr_ready=0 while feeding 8×(FIFO_DEPTH+2) samples, then release.
  - Expect overflow=1 and exactly FIFO_DEPTH writes.
  - wr_data/wr_addr must stay stable while stalled; recorded_words=16.
- Start with base_addr=0xFFFFFF and feed 16 samples.
  - Expect the addresses 0xFFFFFF then 0x000000.
- Assert rst low while a word is stalled with wr_valid=1.
  - Expect all outputs 0 immediately, without waiting for a clock edge, and no done pulse.
  - Expect a subsequent start to record normally.
- Pulse start and stop in the same cycle in IDLE.
  - Expect busy=1 and the take still recording.
